// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, mux selects
// and the control word. MULTICYCLE_CONTROL_BNE_EN adds bne to the DECODE dispatch.
package multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       instr_done;
    } ctrl_t;

    // Successor of DECODE; unknown opcodes retire immediately as NOPs.
    function automatic state_t decode_next(input logic [5:0] op);
        state_t nxt;
        case (op)
            OP_LW, OP_SW: nxt = S_MEMADR;
            OP_RTYPE:     nxt = S_EXEC;
            OP_BEQ:       nxt = S_BRANCH;
`ifdef MULTICYCLE_CONTROL_BNE_EN
            OP_BNE:       nxt = S_BRANCH;
`endif
            OP_ADDI:      nxt = S_ADDIEX;
            OP_J:         nxt = S_JUMP;
            default:      nxt = S_FETCH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state -> control word mapping for the multicycle controller.
// Reset forces all enables low while keeping the FETCH mux selects.
module mc_output_decode
    import multicycle_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    input  logic       reset,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        if (reset) begin
            ctrl.alusrcb = SRCB_FOUR;
        end else begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_req = 1'b1;
                    ctrl.alusrcb = SRCB_FOUR;
                    ctrl.aluop   = ALUOP_ADD;
                    ctrl.pcsrc   = PCSRC_ALU;
                    ctrl.irwrite = mem_ready;
                    ctrl.pcen    = mem_ready;
                end
                S_DECODE: begin
                    ctrl.alusrcb    = SRCB_IMM_SH;
                    ctrl.aluop      = ALUOP_ADD;
                    ctrl.instr_done = (decode_next(opcode) == S_FETCH);
                end
                S_MEMADR, S_ADDIEX: begin
                    ctrl.alusrca = 1'b1;
                    ctrl.alusrcb = SRCB_IMM;
                    ctrl.aluop   = ALUOP_ADD;
                end
                S_MEMRD: begin
                    ctrl.mem_req = 1'b1;
                    ctrl.iord    = 1'b1;
                end
                S_MEMWB: begin
                    ctrl.regwrite   = 1'b1;
                    ctrl.memtoreg   = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                S_MEMWR: begin
                    // Write enable held for the whole wait; memory commits on the ready cycle.
                    ctrl.mem_req    = 1'b1;
                    ctrl.memwrite   = 1'b1;
                    ctrl.iord       = 1'b1;
                    ctrl.instr_done = mem_ready;
                end
                S_EXEC: begin
                    ctrl.alusrca = 1'b1;
                    ctrl.alusrcb = SRCB_B;
                    ctrl.aluop   = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    ctrl.regwrite   = 1'b1;
                    ctrl.regdst     = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alusrca    = 1'b1;
                    ctrl.alusrcb    = SRCB_B;
                    ctrl.aluop      = ALUOP_SUB;
                    ctrl.pcsrc      = PCSRC_ALUOUT;
                    ctrl.pcen       = branch_taken;
                    ctrl.instr_done = 1'b1;
                end
                S_ADDIWB: begin
                    ctrl.regwrite   = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                S_JUMP: begin
                    ctrl.pcsrc      = PCSRC_JUMP;
                    ctrl.pcen       = 1'b1;
                    ctrl.instr_done = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory-ready stalls and a sticky wait timeout.
// Define MULTICYCLE_CONTROL_BNE_EN to add bne alongside beq.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter logic [3:0]  RESET_STATE  = 4'd0,
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       mem_timeout
);

    state_t     state_q;
    logic [3:0] wait_cnt;
    logic       waiting;
    logic       branch_taken;
    ctrl_t      ctrl;

`ifdef MULTICYCLE_CONTROL_BNE_EN
    logic is_bne;
    assign branch_taken = is_bne ? !zero : zero;
`else
    assign branch_taken = zero;
`endif

    assign waiting = !mem_ready &&
                     ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= state_t'(RESET_STATE);
            wait_cnt    <= 4'd0;
            mem_timeout <= 1'b0;
`ifdef MULTICYCLE_CONTROL_BNE_EN
            is_bne      <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_FETCH:  if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    state_q <= decode_next(opcode);
`ifdef MULTICYCLE_CONTROL_BNE_EN
                    is_bne  <= opcode[0];
`endif
                end
                S_MEMADR: state_q <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (mem_ready) state_q <= S_MEMWB;
                S_MEMWR:  if (mem_ready) state_q <= S_FETCH;
                S_EXEC:   state_q <= S_ALUWB;
                S_ADDIEX: state_q <= S_ADDIWB;
                default:  state_q <= S_FETCH;
            endcase

            // Waits only happen while the state is held, so clearing on !waiting
            // also covers every state change.
            if (waiting) begin
                if (wait_cnt != 4'hF) wait_cnt <= wait_cnt + 4'd1;
                if ((MEM_WAIT_MAX != 0) && ((32'(wait_cnt) + 32'd1) >= MEM_WAIT_MAX))
                    mem_timeout <= 1'b1;
            end else begin
                wait_cnt <= 4'd0;
            end
        end
    end

    mc_output_decode u_decode (
        .state        (state_q),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .branch_taken (branch_taken),
        .reset        (reset),
        .ctrl         (ctrl)
    );

    assign mem_req    = ctrl.mem_req;
    assign memwrite   = ctrl.memwrite;
    assign iord       = ctrl.iord;
    assign irwrite    = ctrl.irwrite;
    assign regwrite   = ctrl.regwrite;
    assign regdst     = ctrl.regdst;
    assign memtoreg   = ctrl.memtoreg;
    assign alusrca    = ctrl.alusrca;
    assign alusrcb    = ctrl.alusrcb;
    assign aluop      = ctrl.aluop;
    assign pcsrc      = ctrl.pcsrc;
    assign pcen       = ctrl.pcen;
    assign instr_done = ctrl.instr_done;
    assign state      = state_q;

endmodule
